i2s_rx_sequencer: RTL and testbench

Master-mode I2S receive controller that drives the codec's bit clock (`sck_o`) and word select (`ws_o`). It captures serial data on `sd_i` into signed PCM words per channel and hands each completed word to downstream logic through a single-entry valid/ready output register. It sits between the chip pins and the sample-processing datapath. It replaces free-running WS generation with a controlled, startable and stoppable frame sequence.

---
 rtl/i2s_rx_sequencer_pkg.sv | 12 +
 rtl/i2s_rx_sequencer_sck_gen.sv | 40 ++++
 rtl/i2s_rx_sequencer.sv | 113 +++++++++++
 tb/tb_i2s_rx_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_sequencer_pkg.sv
// i2s_pkg: shared types and constants for the I2S receive sequencer.
//   state_t            : sequencer state (IDLE, RUN)
//   CHAN_LEFT/RIGHT    : word-select / channel encoding
//   *_DEF              : default parameter values
package i2s_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam logic CHAN_LEFT = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;
  localparam int SAMPLE_BITS_DEF = 8;
  localparam int SLOT_BITS_DEF = 16;
  localparam int SCK_DIV_DEF = 2;
endpackage

// File: rtl/i2s_rx_sequencer_sck_gen.sv
// i2s_sck_gen: bit-clock divider with single-cycle toggle strobes.
//   clk, reset   : system clock, synchronous active-high reset
//   en_i         : run the divider; low parks sck_o at 0 and clears the count
//   sck_o        : bit clock, SCK_DIV clk cycles per half-period
//   rise_stb_o   : high in the cycle whose edge takes sck_o 0->1
//   fall_stb_o   : high in the cycle whose edge takes sck_o 1->0
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int SCK_DIV = SCK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic sck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);
  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(SCK_DIV - 1);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic sck_q, sck_d, tick;
  assign tick = en_i && div_cnt_q == DMAX;
  assign rise_stb_o = tick && !sck_q;
  assign fall_stb_o = tick && sck_q;
  assign sck_o = sck_q;
  always_comb begin
    div_cnt_d = (!en_i || tick) ? '0 : div_cnt_q + 1'b1;
    sck_d = !en_i ? 1'b0 : tick ? ~sck_q : sck_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q <= sck_d;
    end
  end
endmodule

// File: rtl/i2s_rx_sequencer.sv
// i2s_rx_sequencer: master-mode I2S receiver with startable/stoppable framing.
//   clk, reset        : system clock, synchronous active-high reset
//   enable            : start framing; low stops at the end of a right slot
//   sd_i              : serial data from codec (already synchronised)
//   sck_o, ws_o       : bit clock and word select (0 = left, 1 = right)
//   out_data/out_chan : completed sample and its channel
//   out_valid/ready   : single-entry output register handshake
//   overrun           : sticky, a completed sample was dropped
//   overrun_clr       : clears overrun (a same-cycle drop wins)
//   busy              : high while framing
// Build option I2S_SEQ_MONO_EN: deliver left-slot samples only.
module i2s_rx_sequencer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int SCK_DIV = SCK_DIV_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sd_i,
  output logic                   sck_o,
  output logic                   ws_o,
  output logic [SAMPLE_BITS-1:0] out_data,
  output logic                   out_chan,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   busy
);
  localparam int BW = $clog2(SLOT_BITS);
  localparam logic [BW-1:0] LAST = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] SB = BW'(SAMPLE_BITS);
  localparam logic [BW-1:0] SMSB = BW'(SAMPLE_BITS - 1);
  state_t state_q, state_d;
  logic ws_q, ws_d;
  logic [BW-1:0] bit_pos_q, bit_pos_d, bit_pos_nx;
  logic [SAMPLE_BITS-2:0] sh_q, sh_d;
  logic [SAMPLE_BITS-1:0] word, out_data_q, out_data_d;
  logic out_chan_q, out_chan_d, out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic rise_stb, fall_stb, cap, done, load, drop, stop;
  i2s_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck (
    .clk        (clk),
    .reset      (reset),
    .en_i       (state_q == ST_RUN),
    .sck_o      (sck_o),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );
  assign bit_pos_nx = (bit_pos_q == LAST) ? '0 : bit_pos_q + 1'b1;
  assign cap = rise_stb && bit_pos_q < SB;
  // The LSB is folded in combinationally so the word completes on its own edge.
  assign word = {sh_q, sd_i};
`ifdef I2S_SEQ_MONO_EN
  assign done = cap && bit_pos_q == SMSB && ws_q == CHAN_LEFT;
`else
  assign done = cap && bit_pos_q == SMSB;
`endif
  assign load = done && (!out_valid_q || out_ready);
  assign drop = done && !load;
  // Stopping only where a right slot ends keeps every started frame whole.
  assign stop = fall_stb && bit_pos_nx == LAST && ws_q == CHAN_RIGHT && !enable;
  always_comb begin
    state_d = state_q;
    ws_d = ws_q;
    bit_pos_d = bit_pos_q;
    sh_d = cap ? word[SAMPLE_BITS-2:0] : sh_q;
    if (state_q == ST_IDLE && enable) begin
      state_d = ST_RUN;
      ws_d = CHAN_LEFT;
      bit_pos_d = LAST;
    end else if (stop) begin
      state_d = ST_IDLE;
      ws_d = CHAN_RIGHT;
    end else if (fall_stb) begin
      bit_pos_d = bit_pos_nx;
      ws_d = (bit_pos_nx == LAST) ? ~ws_q : ws_q;
    end
    out_valid_d = load | (out_valid_q & ~out_ready);
    out_data_d = load ? word : out_data_q;
    out_chan_d = load ? ws_q : out_chan_q;
    overrun_d = drop | (overrun_q & ~overrun_clr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ws_q <= CHAN_RIGHT;
      bit_pos_q <= '0;
      sh_q <= '0;
      out_data_q <= '0;
      out_chan_q <= CHAN_LEFT;
      out_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q <= ws_d;
      bit_pos_q <= bit_pos_d;
      sh_q <= sh_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      out_valid_q <= out_valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign ws_o = ws_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  assign out_valid = out_valid_q;
  assign overrun = overrun_q;
  assign busy = state_q == ST_RUN;
endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// tb_i2s_rx_sequencer: self-checking bench for i2s_rx_sequencer.
module tb_i2s_rx_sequencer;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, sd_i = 1'b0, out_ready = 1'b0, overrun_clr = 1'b0;
  logic sck_o, ws_o, out_chan, out_valid, overrun, busy;
  logic [7:0] out_data;
  int cyc = 0, e0 = 0, n_cmp = 0, n_err = 0;
  logic [7:0] lw [4];
  logic [7:0] rw [4];
  logic [8:0] sb_q [$];

  i2s_rx_sequencer #(.SAMPLE_BITS(8), .SLOT_BITS(16), .SCK_DIV(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sd_i(sd_i), .sck_o(sck_o), .ws_o(ws_o),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Codec model: holds each slot bit for a full SCK period ending at its capture
  // edge E0+6+4q (q = bit index since the first left bit); unused bits are random.
  always @(negedge clk) begin : codec
    int u, q, p;
    logic [7:0] w;
    #1;
    u = cyc + 1 - e0 - 6;
    if (u < 0) sd_i = 1'($urandom_range(1));
    else begin
      q = (u + 3) / 4;
      p = q % 32;
      w = (p >= 16) ? rw[(q / 32) % 4] : lw[(q / 32) % 4];
      sd_i = (p % 16 < 8) ? w[7 - p % 16] : 1'($urandom_range(1));
    end
  end

  // Scoreboard: every accepted handshake must match the oldest expected word.
  always @(negedge clk) begin : monitor
    logic [8:0] exp_w;
    #4;
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected got=%h exp=none", {out_chan, out_data});
      end else begin
        exp_w = sb_q.pop_front();
        if ({out_chan, out_data} !== exp_w) begin
          n_err++;
          $display("FAIL sb_word got=%h exp=%h", {out_chan, out_data}, exp_w);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic at(input int n);
    while (cyc < e0 + n) @(negedge clk);
  endtask

  task automatic start();
    enable = 1'b1;
    e0 = cyc + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (sck_o !== 1'b0) begin n_err++; $display("FAIL rst_sck got=%b exp=0", sck_o); end
    n_cmp++; if (ws_o !== 1'b1) begin n_err++; $display("FAIL rst_ws got=%b exp=1", ws_o); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data got=%h exp=00", out_data); end
    n_cmp++; if (out_chan !== 1'b0) begin n_err++; $display("FAIL rst_chan got=%b exp=0", out_chan); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic ps, pw;
    out_ready = 1'b1;
    lw[0] = 8'hA5; rw[0] = 8'h3C;
    sb_q.push_back({1'b0, 8'hA5}); sb_q.push_back({1'b1, 8'h3C});
    start();
    at(0);
    n_cmp++; if (busy !== 1'b1 || ws_o !== 1'b0) begin n_err++; $display("FAIL basic_e0 got=busy%b/ws%b exp=busy1/ws0", busy, ws_o); end
    ps = sck_o; pw = ws_o;
    for (int n = 1; n <= 130; n++) begin
      at(n);
      if (ws_o !== pw) begin
        n_cmp++; if (!(ps === 1'b1 && sck_o === 1'b0)) begin n_err++; $display("FAIL ws_edge@%0d got=sck%b->%b exp=1->0", n, ps, sck_o); end
      end
      if (n == 2 || n == 6) begin n_cmp++; if (sck_o !== 1'b1) begin n_err++; $display("FAIL sck_rise@%0d got=%b exp=1", n, sck_o); end end
      if (n == 1 || n == 4) begin n_cmp++; if (sck_o !== 1'b0) begin n_err++; $display("FAIL sck_low@%0d got=%b exp=0", n, sck_o); end end
      if (n == 33 || n == 97) begin n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early@%0d got=%b exp=0", n, out_valid); end end
      if (n == 34) begin n_cmp++; if ({out_valid, out_chan, out_data} !== {1'b1, 1'b0, 8'hA5}) begin n_err++; $display("FAIL basic_left got=%b/%b/%h exp=1/0/a5", out_valid, out_chan, out_data); end end
      if (n == 98) begin n_cmp++; if ({out_valid, out_chan, out_data} !== {1'b1, 1'b1, 8'h3C}) begin n_err++; $display("FAIL basic_right got=%b/%b/%h exp=1/1/3c", out_valid, out_chan, out_data); end end
      if (n == 63) begin n_cmp++; if (ws_o !== 1'b0) begin n_err++; $display("FAIL ws_pre got=%b exp=0", ws_o); end end
      if (n == 64) begin n_cmp++; if (ws_o !== 1'b1) begin n_err++; $display("FAIL ws_rise got=%b exp=1", ws_o); end end
      if (n == 99) enable = 1'b0;
      if (n == 127) begin n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy127 got=%b exp=1", busy); end end
      if (n == 128) begin n_cmp++; if ({busy, sck_o, ws_o} !== 3'b001) begin n_err++; $display("FAIL basic_stop got=%b exp=001", {busy, sck_o, ws_o}); end end
      ps = sck_o; pw = ws_o;
    end
  endtask

  task automatic test_stop_restart();
    out_ready = 1'b1;
    lw[0] = 8'h69; rw[0] = 8'h96;
    sb_q.push_back({1'b0, 8'h69}); sb_q.push_back({1'b1, 8'h96});
    start();
    at(20); enable = 1'b0;
    at(98);
    n_cmp++; if ({out_valid, out_chan, out_data} !== {1'b1, 1'b1, 8'h96}) begin n_err++; $display("FAIL stop_right got=%b/%b/%h exp=1/1/96", out_valid, out_chan, out_data); end
    at(127);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stop_busy127 got=%b exp=1", busy); end
    at(128);
    n_cmp++; if ({busy, sck_o, ws_o} !== 3'b001) begin n_err++; $display("FAIL stop_idle got=%b exp=001", {busy, sck_o, ws_o}); end
    at(140);
    n_cmp++; if ({busy, sck_o, ws_o} !== 3'b001) begin n_err++; $display("FAIL stop_hold got=%b exp=001", {busy, sck_o, ws_o}); end
    lw[0] = 8'h0F; rw[0] = 8'hF0;
    sb_q.push_back({1'b0, 8'h0F}); sb_q.push_back({1'b1, 8'hF0});
    start();
    at(0);
    n_cmp++; if ({busy, ws_o} !== 2'b10) begin n_err++; $display("FAIL restart_e0 got=%b exp=10", {busy, ws_o}); end
    at(2);
    n_cmp++; if (sck_o !== 1'b1) begin n_err++; $display("FAIL restart_sck got=%b exp=1", sck_o); end
    at(34);
    n_cmp++; if ({out_valid, out_chan, out_data} !== {1'b1, 1'b0, 8'h0F}) begin n_err++; $display("FAIL restart_left got=%b/%b/%h exp=1/0/0f", out_valid, out_chan, out_data); end
    at(40); enable = 1'b0;
    at(130);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL restart_stop got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    lw[0] = 8'h11; rw[0] = 8'h22; lw[1] = 8'h77; rw[1] = 8'h88;
    sb_q.push_back({1'b0, 8'h11});
    start();
    at(34);
    n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'h11}) begin n_err++; $display("FAIL bp_first got=%b/%h exp=1/11", out_valid, out_data); end
    at(97);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_no_ovr got=%b exp=0", overrun); end
    at(98);
    n_cmp++; if ({overrun, out_valid, out_chan, out_data} !== {1'b1, 1'b1, 1'b0, 8'h11}) begin n_err++; $display("FAIL bp_drop got=%b/%b/%b/%h exp=1/1/0/11", overrun, out_valid, out_chan, out_data); end
    at(99); overrun_clr = 1'b1;
    at(100); overrun_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_clr got=%b exp=0", overrun); end
    at(161); overrun_clr = 1'b1;
    at(162); overrun_clr = 1'b0;
    n_cmp++; if ({overrun, out_data} !== {1'b1, 8'h11}) begin n_err++; $display("FAIL bp_clr_drop got=%b/%h exp=1/11", overrun, out_data); end
    at(170); enable = 1'b0;
    at(257);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_stop got=%b exp=0", busy); end
    at(260); out_ready = 1'b1;
    at(262);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    overrun_clr = 1'b1;
    at(263); overrun_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_final_clr got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    lw[0] = 8'h5A; rw[0] = 8'hC3;
    sb_q.push_back({1'b0, 8'h5A}); sb_q.push_back({1'b1, 8'hC3});
    start();
    at(97);
    n_cmp++; if ({out_valid, out_data} !== {1'b1, 8'h5A}) begin n_err++; $display("FAIL b2b_hold got=%b/%h exp=1/5a", out_valid, out_data); end
    out_ready = 1'b1;
    at(98); out_ready = 1'b0;
    n_cmp++; if ({out_valid, out_chan, out_data, overrun} !== {1'b1, 1'b1, 8'hC3, 1'b0}) begin n_err++; $display("FAIL b2b_load got=%b/%b/%h/%b exp=1/1/c3/0", out_valid, out_chan, out_data, overrun); end
    at(100); enable = 1'b0;
    at(130); out_ready = 1'b1;
    at(132);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    int seen;
    out_ready = 1'b1;
    lw[0] = 8'hB7; rw[0] = 8'h00;
    start();
    at(19); reset = 1'b1; enable = 1'b0;
    at(20);
    n_cmp++; if ({busy, sck_o, ws_o, out_valid, out_chan, overrun} !== 6'b001000) begin n_err++; $display("FAIL mrst_ctrl got=%b exp=001000", {busy, sck_o, ws_o, out_valid, out_chan, overrun}); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL mrst_data got=%h exp=00", out_data); end
    at(22); reset = 1'b0;
    seen = 0;
    for (int n = 23; n <= 70; n++) begin at(n); if (out_valid === 1'b1) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mrst_novalid got=%0d exp=0", seen); end
    lw[0] = 8'hD2; rw[0] = 8'h4B;
    sb_q.push_back({1'b0, 8'hD2}); sb_q.push_back({1'b1, 8'h4B});
    start();
    at(34);
    n_cmp++; if ({out_valid, out_chan, out_data} !== {1'b1, 1'b0, 8'hD2}) begin n_err++; $display("FAIL mrst_left got=%b/%b/%h exp=1/0/d2", out_valid, out_chan, out_data); end
    at(40); enable = 1'b0;
    at(98);
    n_cmp++; if ({out_valid, out_chan, out_data} !== {1'b1, 1'b1, 8'h4B}) begin n_err++; $display("FAIL mrst_right got=%b/%b/%h exp=1/1/4b", out_valid, out_chan, out_data); end
    at(132);
  endtask

  initial begin
    foreach (lw[i]) begin lw[i] = 8'h00; rw[i] = 8'h00; end
    test_reset();
    test_basic();
    test_stop_restart();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
